// File: rtl/vec_batch_sched.sv
// vec_batch_sched: time-shares one vec_cat between the reference-load stream
// and the compare stream. Each batch runs one fixed-size reference load, a
// vec_cat flush, then the compare stream, followed by a final flush.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_FLUSH     | vec_cat held in reset; counts down, then goes to flush_to
// S_IDLE      | waiting for start
// S_REF       | reference words passed through to vec_cat
// S_REF_DRAIN | last reference word taken; waiting for vec_cat to drain
// S_CMP       | compare words passed through to vec_cat
// S_CMP_DRAIN | last compare word taken; waiting for vec_cat to drain
module vec_batch_sched #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int REF_VEC_NO   = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err_Len,
  input  logic [BUS_WIDTH-1:0] ref_Vector,
  input  logic                 ref_Valid,
  input  logic                 ref_Last,
  output logic                 ref_Ready,
  input  logic [BUS_WIDTH-1:0] cmp_Vector,
  input  logic                 cmp_Valid,
  input  logic                 cmp_Last,
  output logic                 cmp_Ready,
  output logic [BUS_WIDTH-1:0] cat_Vector,
  output logic                 cat_Valid,
  output logic                 cat_Last,
  input  logic                 cat_Ready,
  input  logic                 cat_DnLast,
  output logic                 cat_Rstn,
  output logic                 cat_Sel,
  output logic [CNT_WIDTH-1:0] cmp_WordCnt
);

  localparam int REF_WORDS = (REF_VEC_NO * VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int RW_W      = $clog2(REF_WORDS + 1);
  localparam int FL_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [RW_W-1:0] REF_LAST_IDX = RW_W'(REF_WORDS - 1);
  localparam logic [FL_W-1:0] FL_INIT      = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FLUSH     = 3'd0,
    S_IDLE      = 3'd1,
    S_REF       = 3'd2,
    S_REF_DRAIN = 3'd3,
    S_CMP       = 3'd4,
    S_CMP_DRAIN = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 flush_to_q, flush_to_d;   // 1 = CMP, 0 = IDLE
  logic [FL_W-1:0]      fcnt_q, fcnt_d;
  logic [RW_W-1:0]      rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0] ccnt_q, ccnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 arm_q, arm_d;             // the coming IDLE exit ends a batch
  logic                 sel_q, sel_d;

  logic ref_at_end;
  assign ref_at_end = (rcnt_q == REF_LAST_IDX);

  // State and datapath registers; reset lands in FLUSH so vec_cat is always cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FLUSH;
      flush_to_q <= 1'b0;
      fcnt_q     <= FL_INIT;
      rcnt_q     <= '0;
      ccnt_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_to_q <= flush_to_d;
      fcnt_q     <= fcnt_d;
      rcnt_q     <= rcnt_d;
      ccnt_q     <= ccnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      arm_q      <= arm_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state logic and the per-state stream muxing.
  always_comb begin
    state_d    = state_q;
    flush_to_d = flush_to_q;
    fcnt_d     = fcnt_q;
    rcnt_d     = rcnt_q;
    ccnt_d     = ccnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    arm_d      = arm_q;
    cat_Vector = '0;
    cat_Valid  = 1'b0;
    cat_Last   = 1'b0;
    ref_Ready  = 1'b0;
    cmp_Ready  = 1'b0;
    cat_Rstn   = 1'b1;

    case (state_q)
      S_FLUSH: begin
        cat_Rstn = 1'b0;
        if (fcnt_q == '0) begin
          if (flush_to_q) begin
            state_d = S_CMP;
          end else begin
            state_d = S_IDLE;
            done_d  = arm_q;
            arm_d   = 1'b0;
          end
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_REF;
          err_d   = 1'b0;
          rcnt_d  = '0;
          ccnt_d  = '0;
        end
      end
      S_REF: begin
        cat_Vector = ref_Vector;
        cat_Valid  = ref_Valid;
        ref_Ready  = cat_Ready;
        // The word count forces a last so vec_cat never sees an overlong load.
        cat_Last   = ref_Last | ref_at_end;
        if (ref_Valid && cat_Ready) begin
          rcnt_d = rcnt_q + 1'b1;
          if (cat_Last) begin
            state_d = S_REF_DRAIN;
            if (!(ref_Last && ref_at_end)) begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_REF_DRAIN: begin
        if (cat_DnLast) begin
          state_d    = S_FLUSH;
          flush_to_d = 1'b1;
          fcnt_d     = FL_INIT;
        end
      end
      S_CMP: begin
        cat_Vector = cmp_Vector;
        cat_Valid  = cmp_Valid;
        cmp_Ready  = cat_Ready;
        cat_Last   = cmp_Last;
        if (cmp_Valid && cat_Ready) begin
          if (ccnt_q != '1) begin
            ccnt_d = ccnt_q + 1'b1;
          end
          if (cmp_Last) begin
            state_d = S_CMP_DRAIN;
          end
        end
      end
      S_CMP_DRAIN: begin
        if (cat_DnLast) begin
          state_d    = S_FLUSH;
          flush_to_d = 1'b0;
          fcnt_d     = FL_INIT;
          arm_d      = 1'b1;
        end
      end
      default: begin
        state_d    = S_FLUSH;
        flush_to_d = 1'b0;
        fcnt_d     = FL_INIT;
      end
    endcase

    sel_d = (state_d == S_CMP) || (state_d == S_CMP_DRAIN) ||
            ((state_d == S_FLUSH) && flush_to_d);
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_Len     = err_q;
  assign cat_Sel     = sel_q;
  assign cmp_WordCnt = ccnt_q;

endmodule

// File: tb/tb_vec_batch_sched.sv
// Bench for vec_batch_sched: a source driver pushes each offered word into a
// scoreboard and a monitor on the vec_cat side pops and compares.
module tb_vec_batch_sched;

  localparam int BW        = 128;
  localparam int REF_WORDS = 115;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err_Len;
  logic [BW-1:0] ref_Vector = '0;
  logic          ref_Valid = 1'b0, ref_Last = 1'b0, ref_Ready;
  logic [BW-1:0] cmp_Vector = '0;
  logic          cmp_Valid = 1'b0, cmp_Last = 1'b0, cmp_Ready;
  logic [BW-1:0] cat_Vector;
  logic          cat_Valid, cat_Last;
  logic          cat_Ready = 1'b1;
  logic          cat_DnLast = 1'b0;
  logic          cat_Rstn, cat_Sel;
  logic [15:0]   cmp_WordCnt;

  vec_batch_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err_Len(err_Len),
    .ref_Vector(ref_Vector), .ref_Valid(ref_Valid), .ref_Last(ref_Last), .ref_Ready(ref_Ready),
    .cmp_Vector(cmp_Vector), .cmp_Valid(cmp_Valid), .cmp_Last(cmp_Last), .cmp_Ready(cmp_Ready),
    .cat_Vector(cat_Vector), .cat_Valid(cat_Valid), .cat_Last(cat_Last), .cat_Ready(cat_Ready),
    .cat_DnLast(cat_DnLast), .cat_Rstn(cat_Rstn), .cat_Sel(cat_Sel), .cmp_WordCnt(cmp_WordCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          sel;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_words = 0;
  int   done_cnt = 0;
  bit   bp_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // vec_cat side ready: random when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    cat_Ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every vec_cat handshake must match the next offered word.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (cat_Valid && cat_Ready) begin
        exp_t e;
        n_words++;
        if (sb.size() == 0) begin
          chk("sb_extra_word", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("cat_vec", cat_Vector, e.data);
          chk("cat_last", 128'(cat_Last), 128'(e.last));
          chk("cat_sel", 128'(cat_Sel), 128'(e.sel));
        end
      end
    end
  end

  // Offer n words on one stream; last_pos is the 1-based source last (0 = none).
  task automatic send_words(input bit sel, input int n, input int last_pos,
                            input bit gaps, input int start_at);
    logic [BW-1:0] w;
    bit lst, exp_last, hs, ok;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      w = {$urandom, $urandom, $urandom, $urandom};
      lst = (i + 1 == last_pos);
      exp_last = lst || (!sel && (i + 1 == REF_WORDS));
      if (sel) begin
        cmp_Vector = w; cmp_Last = lst; cmp_Valid = 1'b1;
      end else begin
        ref_Vector = w; ref_Last = lst; ref_Valid = 1'b1;
      end
      sb.push_back('{data: w, last: exp_last, sel: sel});
      if (i == start_at) start = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        hs = sel ? cmp_Ready : ref_Ready;
        @(posedge clk); #1;
        start = 1'b0;
        if (hs) begin
          ok = 1'b1;
          break;
        end
      end
      ref_Valid = 1'b0; ref_Last = 1'b0;
      cmp_Valid = 1'b0; cmp_Last = 1'b0;
      if (!ok) begin
        chk("handshake_timeout", 128'(0), 128'(1));
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic begin_batch();
    wait_idle();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_err_clr", 128'(err_Len), 128'(0));
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_sel", 128'(cat_Sel), 128'(0));
  endtask

  task automatic pulse_dnlast();
    repeat (3) @(posedge clk);
    #1 cat_DnLast = 1'b1;
    @(posedge clk); #1 cat_DnLast = 1'b0;
  endtask

  task automatic run_batch(input int nref, input int ref_last, input int ncmp,
                           input bit gaps, input bit exp_err, input bit hold,
                           input int start_at);
    int w0, d0;
    begin_batch();
    w0 = n_words;
    d0 = done_cnt;
    bp_en = gaps;
    send_words(1'b0, nref, ref_last, gaps, start_at);
    chk("ref_err", 128'(err_Len), 128'(exp_err));
    chk("ref_rdy_drain", 128'(ref_Ready), 128'(0));
    if (hold) begin
      ref_Valid = 1'b1;
      ref_Vector = {4{32'hDEAD_BEEF}};
      repeat (4) begin
        @(negedge clk);
        chk("ref_rdy_hold", 128'(ref_Ready), 128'(0));
      end
      @(posedge clk); #1 ref_Valid = 1'b0;
    end
    chk("drain_sel", 128'(cat_Sel), 128'(0));
    pulse_dnlast();
    chk("flush1_rstn", 128'(cat_Rstn), 128'(0));
    chk("flush1_sel", 128'(cat_Sel), 128'(1));
    send_words(1'b1, ncmp, ncmp, gaps, -1);
    bp_en = 1'b0;
    chk("cmp_cnt", 128'(cmp_WordCnt), 128'(ncmp));
    chk("cmp_drain_sel", 128'(cat_Sel), 128'(1));
    pulse_dnlast();
    @(negedge clk);
    chk("flush2_rstn_a", 128'(cat_Rstn), 128'(0));
    chk("flush2_done_a", 128'(done), 128'(0));
    @(negedge clk);
    chk("flush2_rstn_b", 128'(cat_Rstn), 128'(0));
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_idle", 128'(busy), 128'(0));
    chk("done_sel", 128'(cat_Sel), 128'(0));
    @(negedge clk);
    chk("done_single", 128'(done), 128'(0));
    chk("batch_done_cnt", 128'(done_cnt - d0), 128'(1));
    chk("batch_err_sticky", 128'(err_Len), 128'(exp_err));
    chk("batch_words", 128'(n_words - w0), 128'(nref + ncmp));
    chk("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset behaviour.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rstn", 128'(cat_Rstn), 128'(0));
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err_Len), 128'(0));
    chk("rst_sel", 128'(cat_Sel), 128'(0));
    chk("rst_cnt", 128'(cmp_WordCnt), 128'(0));
    chk("rst_rdy", 128'({ref_Ready, cmp_Ready, cat_Valid, cat_Last}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rstn0", 128'(cat_Rstn), 128'(0));
    @(negedge clk);
    chk("post_rst_rstn1", 128'(cat_Rstn), 128'(0));
    chk("post_rst_busy1", 128'(busy), 128'(1));
    @(negedge clk);
    chk("post_rst_rstn2", 128'(cat_Rstn), 128'(1));
    chk("post_rst_idle", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("post_rst_no_done", 128'(done_cnt), 128'(0));

    // Nominal batch, early last, missing last, backpressure, start during REF.
    run_batch(115, 115, 40, 1'b0, 1'b0, 1'b0, -1);
    run_batch(100, 100, 12, 1'b0, 1'b1, 1'b0, -1);
    run_batch(115, 0,   7,  1'b0, 1'b1, 1'b1, -1);
    run_batch(115, 115, 40, 1'b1, 1'b0, 1'b0, -1);
    run_batch(115, 115, 20, 1'b0, 1'b0, 1'b0, 50);

    // Asynchronous reset in the middle of the compare phase.
    d0 = done_cnt;
    begin_batch();
    send_words(1'b0, 115, 115, 1'b0, -1);
    pulse_dnlast();
    send_words(1'b1, 10, 0, 1'b0, -1);
    cmp_Valid = 1'b1;
    cmp_Vector = {4{32'h0BAD_F00D}};
    @(negedge clk);
    chk("abort_pre_rdy", 128'(cmp_Ready), 128'(1));
    chk("abort_pre_cnt", 128'(cmp_WordCnt), 128'(10));
    rst = 1'b1;
    #1;
    chk("abort_rdy", 128'(cmp_Ready), 128'(0));
    chk("abort_rstn", 128'(cat_Rstn), 128'(0));
    chk("abort_cnt", 128'(cmp_WordCnt), 128'(0));
    chk("abort_valid", 128'(cat_Valid), 128'(0));
    chk("abort_sel", 128'(cat_Sel), 128'(0));
    cmp_Valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
    chk("abort_sb_empty", 128'(sb.size()), 128'(0));

    // Recovery after the abort.
    run_batch(115, 115, 5, 1'b0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
